pd_rx_dec_5b4b: RTL and testbench
=================================

Name: pd_rx_dec_5b4b

Overview:
- Receive-side counterpart of the PD 4b5b transmit encoder. Consumes the recovered bit stream from the BMC receiver, hunts for a PD ordered set (SOP/SOP'/SOP''/Hard Reset/Cable Reset), then de-serialises 5-bit symbols and decodes them into bytes, low nibble first, until EOP.
- Sits between the BMC bit-recovery block and the PD packet/CRC layer.

Parameters:
- MAX_BYTES, 64, max decoded bytes per frame (header+data+CRC) before overflow error.
- CNT_W, 7, width of the byte counter; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_en  input  1  decoder enable; 0 forces HUNT and clears the shift register
- bit_in  input  1  recovered line bit, valid only when bit_vld=1
- bit_vld  input  1  one-cycle strobe per recovered bit
- sop_vld  output  1  one-cycle pulse: ordered set detected
- sop_type  output  3  1=SOP, 2=SOP', 3=SOP'', 4=Hard Reset, 5=Cable Reset; holds until next sop_vld
- rx_data  output  8  decoded byte, valid when rx_vld=1
- rx_vld  output  1  one-cycle pulse per decoded byte
- eop  output  1  one-cycle pulse: EOP received after an even nibble count
- err  output  1  one-cycle pulse: frame aborted
- err_code  output  2  1=invalid symbol, 2=odd nibble count at EOP, 3=overflow; holds until next err
- busy  output  1  high in states SOP_CHK..DATA (frame in progress)

Behaviour:
- Bit order: the first received bit of a symbol is symbol bit 0. Shift register: sr <= {bit_in, sr[19:1]} on each bit_vld.
- Codes: data 0..F = 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101. K-codes: Sync-1=11000, Sync-2=10001, Sync-3=00110, RST-1=00111, RST-2=11001, EOP=01101.
- Reset: state HUNT; sr, counters and all outputs 0.
- HUNT: shift every bit_vld. Once 20 bits are accumulated, compare sr as K1..K4, where K1=sr[4:0] is the earliest symbol:
  - SOP = S1 S1 S1 S2
  - SOP' = S1 S1 S3 S3
  - SOP'' = S1 S3 S1 S3
  - Hard Reset = R1 R1 R1 R2
  - Cable Reset = R1 S1 R1 S3
- Matching is exact on all 4 K-codes. Preamble and garbage are ignored with no err.
- Match: sop_vld=1 and sop_type updated on the cycle after the matching bit_vld.
  - SOP/SOP'/SOP'': go to DATA, with bit_cnt, nibble flag and byte_cnt cleared.
  - Hard/Cable Reset: return to HUNT with sr cleared; no payload follows.
- DATA: collect 5 bits per symbol (bit_cnt 0..4). On the 5th bit, decode on the following cycle:
  - Data nibble, first of a pair: stored as the low nibble.
  - Data nibble, second of a pair: forms the high nibble. rx_data={hi,lo} and rx_vld=1; byte_cnt increments.
  - EOP with an even nibble count: eop=1, go to HUNT.
  - EOP with an odd nibble count: err=1, err_code=2, go to HUNT.
  - Any other K-code or undefined code: err=1, err_code=1, go to HUNT.
  - Byte that would make byte_cnt exceed MAX_BYTES: not output; err=1, err_code=3, go to HUNT.
- Latency: exactly 1 clk from the qualifying bit_vld to sop_vld/rx_vld/eop/err.
- Pulse exclusivity: at most one of sop_vld, rx_vld, eop, err in any cycle.
- Back-to-back bit_vld on consecutive clocks must be handled with no bit loss.
- Every return to HUNT clears sr and requires 20 fresh bits before the next match.
- rx_en=0: next cycle enters HUNT, clears sr and counters, emits no pulses. An in-progress frame is dropped silently (no err).
- rst mid-frame: identical to the reset state on the next cycle.
- bit_vld=0: state and shift register hold.

Test Plan:
- 64-bit alternating preamble, then SOP (S1 S1 S1 S2) -> sop_vld once, sop_type=1, no err during the preamble.
- SOP followed by nibbles 1,A,3,C then EOP -> rx_data=0xA1 then 0xC3, rx_vld twice, eop one clk after the last EOP bit.
- Hard Reset R1 R1 R1 R2, then further symbols -> sop_type=4, state HUNT, no rx_vld.
- SOP, then nibble 5, then EOP -> err=1, err_code=2, no rx_vld.
- SOP, then nibble 2, then Sync-2 -> err=1, err_code=1.
- With MAX_BYTES=2: SOP plus 3 bytes -> 2 rx_vld, then err_code=3.
- rx_en pulsed low mid-payload -> no further rx_vld or err; a subsequent SOP is detected normally.
- rst asserted mid-payload -> all outputs 0 and busy=0 on the next clk.

Source files
------------

// File: rtl/pd_rx_dec_5b4b.sv
// PD receive 5b4b decoder: ordered-set hunt, symbol deserialise, nibble pairing.
// Emits one-cycle pulses for SOP/byte/EOP/error, registered one clk after the bit.
module pd_rx_dec_5b4b #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic       sop_vld,
  output logic [2:0] sop_type,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       eop,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;

  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

  state_t             state, state_n;
  logic [19:0]        sr, sr_n, sr_sh;
  logic [4:0]         hcnt, hcnt_n;
  logic [2:0]         bcnt, bcnt_n;
  logic               odd, odd_n;
  logic [3:0]         lo, lo_n;
  logic [CNT_W-1:0]   bytes, bytes_n;
  logic               sop_vld_n, rx_vld_n, eop_n, err_n;
  logic [2:0]         sop_type_n, kind;
  logic [7:0]         rx_data_n;
  logic [1:0]         err_code_n;
  logic [4:0]         k1, k2, k3, k4, sym;
  logic               dv;
  logic [3:0]         nib;

  assign sr_sh = {bit_in, sr[19:1]};
  assign k1    = sr_sh[4:0];
  assign k2    = sr_sh[9:5];
  assign k3    = sr_sh[14:10];
  assign k4    = sr_sh[19:15];
  assign sym   = sr_sh[19:15];
  assign busy  = (state == DATA);

  always_comb begin
    kind = 3'd0;
    if (k1 == K_S1 && k2 == K_S1 && k3 == K_S1 && k4 == K_S2) kind = 3'd1;
    if (k1 == K_S1 && k2 == K_S1 && k3 == K_S3 && k4 == K_S3) kind = 3'd2;
    if (k1 == K_S1 && k2 == K_S3 && k3 == K_S1 && k4 == K_S3) kind = 3'd3;
    if (k1 == K_R1 && k2 == K_R1 && k3 == K_R1 && k4 == K_R2) kind = 3'd4;
    if (k1 == K_R1 && k2 == K_S1 && k3 == K_R1 && k4 == K_S3) kind = 3'd5;
  end

  always_comb begin
    dv  = 1'b1;
    nib = 4'h0;
    case (sym)
      5'b11110: nib = 4'h0;
      5'b01001: nib = 4'h1;
      5'b10100: nib = 4'h2;
      5'b10101: nib = 4'h3;
      5'b01010: nib = 4'h4;
      5'b01011: nib = 4'h5;
      5'b01110: nib = 4'h6;
      5'b01111: nib = 4'h7;
      5'b10010: nib = 4'h8;
      5'b10011: nib = 4'h9;
      5'b10110: nib = 4'hA;
      5'b10111: nib = 4'hB;
      5'b11010: nib = 4'hC;
      5'b11011: nib = 4'hD;
      5'b11100: nib = 4'hE;
      5'b11101: nib = 4'hF;
      default:  dv  = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    sr_n       = sr;
    hcnt_n     = hcnt;
    bcnt_n     = bcnt;
    odd_n      = odd;
    lo_n       = lo;
    bytes_n    = bytes;
    sop_vld_n  = 1'b0;
    sop_type_n = sop_type;
    rx_vld_n   = 1'b0;
    rx_data_n  = rx_data;
    eop_n      = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code;
    if (!rx_en) begin
      state_n = HUNT;
      sr_n    = '0;
      hcnt_n  = '0;
      bcnt_n  = '0;
      odd_n   = 1'b0;
      bytes_n = '0;
    end else if (bit_vld) begin
      sr_n = sr_sh;
      unique case (state)
        HUNT: begin
          hcnt_n = (hcnt == 5'd19) ? hcnt : hcnt + 5'd1;
          if (hcnt == 5'd19 && kind != 3'd0) begin
            sop_vld_n  = 1'b1;
            sop_type_n = kind;
            sr_n       = '0;
            hcnt_n     = '0;
            bcnt_n     = '0;
            odd_n      = 1'b0;
            bytes_n    = '0;
            if (kind <= 3'd3) state_n = DATA;
          end
        end
        DATA: begin
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd4) begin
            bcnt_n  = '0;
            state_n = HUNT;
            if (dv && !odd) begin
              state_n = DATA;
              lo_n    = nib;
              odd_n   = 1'b1;
            end else if (dv && bytes == CNT_W'(MAX_BYTES)) begin
              err_n      = 1'b1;
              err_code_n = 2'd3;
            end else if (dv) begin
              state_n   = DATA;
              odd_n     = 1'b0;
              rx_vld_n  = 1'b1;
              rx_data_n = {nib, lo};
              bytes_n   = bytes + CNT_W'(1);
            end else if (sym == K_EOP && !odd) begin
              eop_n = 1'b1;
            end else begin
              err_n      = 1'b1;
              err_code_n = (sym == K_EOP) ? 2'd2 : 2'd1;
            end
            // every exit to HUNT needs a fresh 20-bit window
            if (state_n == HUNT) begin
              sr_n   = '0;
              hcnt_n = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      sr       <= '0;
      hcnt     <= '0;
      bcnt     <= '0;
      odd      <= 1'b0;
      lo       <= '0;
      bytes    <= '0;
      sop_vld  <= 1'b0;
      sop_type <= '0;
      rx_vld   <= 1'b0;
      rx_data  <= '0;
      eop      <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      hcnt     <= hcnt_n;
      bcnt     <= bcnt_n;
      odd      <= odd_n;
      lo       <= lo_n;
      bytes    <= bytes_n;
      sop_vld  <= sop_vld_n;
      sop_type <= sop_type_n;
      rx_vld   <= rx_vld_n;
      rx_data  <= rx_data_n;
      eop      <= eop_n;
      err      <= err_n;
      err_code <= err_code_n;
    end
  end

endmodule

// File: tb/tb_pd_rx_dec_5b4b.sv
// Directed bench for pd_rx_dec_5b4b (MAX_BYTES=2 to reach overflow).
// Pulses are tallied at negedge; latency checked #1 after the bit's edge.
module tb_pd_rx_dec_5b4b;

  logic       clk = 1'b0;
  logic       rst, rx_en, bit_in, bit_vld;
  logic       sop_vld, rx_vld, eop, err, busy;
  logic [2:0] sop_type;
  logic [7:0] rx_data;
  logic [1:0] err_code;

  int n_chk = 0;
  int n_err = 0;
  int c_sop, c_rx, c_eop, c_err, c_mux;
  logic [7:0] rxq[$];

  localparam logic [4:0] S1 = 5'b11000;
  localparam logic [4:0] S2 = 5'b10001;
  localparam logic [4:0] S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111;
  localparam logic [4:0] R2 = 5'b11001;
  localparam logic [4:0] EP = 5'b01101;

  pd_rx_dec_5b4b #(.MAX_BYTES(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en),
    .bit_in(bit_in), .bit_vld(bit_vld),
    .sop_vld(sop_vld), .sop_type(sop_type),
    .rx_data(rx_data), .rx_vld(rx_vld),
    .eop(eop), .err(err), .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sop_vld) c_sop++;
    if (eop) c_eop++;
    if (err) c_err++;
    if (rx_vld) begin
      c_rx++;
      rxq.push_back(rx_data);
    end
    if (int'(sop_vld) + int'(rx_vld) + int'(eop) + int'(err) > 1)
      c_mux++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ncode(input int n);
    case (n)
      0: return 5'b11110;  1: return 5'b01001;
      2: return 5'b10100;  3: return 5'b10101;
      4: return 5'b01010;  5: return 5'b01011;
      6: return 5'b01110;  7: return 5'b01111;
      8: return 5'b10010;  9: return 5'b10011;
      10: return 5'b10110; 11: return 5'b10111;
      12: return 5'b11010; 13: return 5'b11011;
      14: return 5'b11100; default: return 5'b11101;
    endcase
  endfunction

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    @(posedge clk); #1;
    bit_vld = 1'b0;
  endtask

  task automatic send_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
  endtask

  task automatic send_nib(input int n);
    send_sym(ncode(n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clr;
    @(negedge clk);
    c_sop = 0; c_rx = 0; c_eop = 0; c_err = 0;
    rxq.delete();
    @(posedge clk); #1;
  endtask

  task automatic send_sop;
    send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
  endtask

  initial begin
    c_mux = 0;
    rst = 1'b1; rx_en = 1'b1; bit_in = 1'b0; bit_vld = 1'b0;
    idle(3);
    chk("rst_pulses", {sop_vld, rx_vld, eop, err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs", {sop_type, rx_data, err_code}, 0);
    rst = 1'b0;
    clr();

    for (int i = 0; i < 64; i++) send_bit(i[0]);
    chk("pre_nosop", c_sop, 0);
    send_sop();
    chk("sop_lat", sop_vld, 1);
    chk("sop_type", sop_type, 1);
    chk("sop_busy", busy, 1);
    idle(2);
    chk("sop_cnt", c_sop, 1);
    chk("pre_noerr", c_err, 0);

    clr();
    send_nib(1); send_nib(10); send_nib(3); send_nib(12);
    send_sym(EP);
    chk("eop_lat", eop, 1);
    idle(2);
    chk("pl_rx_cnt", c_rx, 2);
    if (rxq.size() == 2) begin
      chk("pl_byte0", rxq[0], 8'hA1);
      chk("pl_byte1", rxq[1], 8'hC3);
    end else chk("pl_qsize", rxq.size(), 2);
    chk("pl_eop_cnt", c_eop, 1);
    chk("pl_err_cnt", c_err, 0);
    chk("pl_busy", busy, 0);

    clr();
    send_sym(R1); send_sym(R1); send_sym(R1); send_sym(R2);
    chk("hr_lat", sop_vld, 1);
    chk("hr_type", sop_type, 4);
    chk("hr_busy", busy, 0);
    send_nib(1); send_nib(2); send_sym(EP);
    idle(2);
    chk("hr_no_rx", c_rx, 0);
    chk("hr_no_eop", c_eop + c_err, 0);

    clr();
    send_sop(); send_nib(5); send_sym(EP);
    chk("odd_err", err, 1);
    chk("odd_code", err_code, 2);
    idle(2);
    chk("odd_no_rx", c_rx + c_eop, 0);

    clr();
    send_sop(); send_nib(2); send_sym(S2);
    chk("kc_err", err, 1);
    chk("kc_code", err_code, 1);
    chk("kc_busy", busy, 0);

    clr();
    send_sop();
    for (int i = 1; i <= 6; i++) send_nib(i);
    chk("ovf_err", err, 1);
    chk("ovf_code", err_code, 3);
    idle(2);
    chk("ovf_rx_cnt", c_rx, 2);
    if (rxq.size() == 2) begin
      chk("ovf_byte0", rxq[0], 8'h21);
      chk("ovf_byte1", rxq[1], 8'h43);
    end else chk("ovf_qsize", rxq.size(), 2);

    clr();
    send_sop(); send_nib(1); send_nib(2); send_nib(3);
    rx_en = 1'b0;
    idle(1);
    chk("en_busy", busy, 0);
    rx_en = 1'b1;
    send_nib(4); send_sym(EP);
    idle(2);
    chk("en_rx_cnt", c_rx, 1);
    chk("en_silent", c_err + c_eop, 0);
    clr();
    send_sop(); send_nib(7); send_nib(8); send_sym(EP);
    idle(2);
    chk("en_resop", c_sop, 1);
    chk("en_rx2", c_rx, 1);
    if (rxq.size() == 1) chk("en_byte", rxq[0], 8'h87);
    else chk("en_qsize", rxq.size(), 1);
    chk("en_eop", c_eop, 1);

    clr();
    send_sop(); send_nib(1); send_nib(2);
    chk("rs_rx_lat", rx_vld, 1);
    send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    idle(1);
    chk("rs_pulses", {sop_vld, rx_vld, eop, err}, 0);
    chk("rs_busy", busy, 0);
    chk("rs_regs", {sop_type, rx_data, err_code}, 0);
    rst = 1'b0;
    idle(2);
    chk("excl", c_mux, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
